// File: rtl/fp_intermediate_wb_receiver.sv
// Collects finished intermediate FP results from several producers into a small FIFO for normalize/round.
// Define FP_WB_ROUND_ROBIN_EN for round-robin grant; otherwise fixed priority, highest index wins.
module fp_intermediate_wb_receiver #(
  parameter int NUM_SOURCES = 2,
  parameter int PAYLOAD_W   = 128,
  parameter int DEPTH       = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_SOURCES-1:0]                src_done,
  input  logic [NUM_SOURCES-1:0][PAYLOAD_W-1:0] src_payload,
  output logic [NUM_SOURCES-1:0]                src_ack,
  output logic                                  out_valid,
  output logic [PAYLOAD_W-1:0]                  out_payload,
  input  logic                                  out_ready,
  output logic [$clog2(DEPTH):0]                occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          occ_q, occ_d;
  logic [PAYLOAD_W-1:0] mem_q [DEPTH];

  logic [GW-1:0] grant;
  logic          any_done;
  logic          full;
  logic          push;
  logic          pop;

`ifdef FP_WB_ROUND_ROBIN_EN
  logic [GW-1:0] rr_q, rr_d;

  // Walk from lowest to highest priority so the source at rr_q is assigned last and wins.
  always_comb begin
    grant    = '0;
    any_done = 1'b0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      if (src_done[(int'(rr_q) + k) % NUM_SOURCES]) begin
        grant    = GW'((int'(rr_q) + k) % NUM_SOURCES);
        any_done = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (push) begin
      rr_d = (grant == GW'(NUM_SOURCES - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`else
  always_comb begin
    grant    = '0;
    any_done = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (src_done[i]) begin
        grant    = GW'(i);
        any_done = 1'b1;
      end
    end
  end
`endif

  // Full comes from registered occupancy only, so out_ready never reaches src_ack.
  assign full    = (occ_q == FULL_CNT);
  assign push    = any_done && !full && !rst;
  assign pop     = (occ_q != '0) && out_ready;
  assign src_ack = push ? (NUM_SOURCES'(1) << grant) : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= src_payload[grant];
  end

  assign out_valid   = (occ_q != '0);
  assign out_payload = mem_q[rd_ptr_q];
  assign occupancy   = occ_q;

endmodule
